snn_spi_regfile: RTL and testbench

SPI mode-0 target and configuration register bank for the SNN core. It sits directly behind the chip-level SPI pins (sclk, cs_n, copi, cipo) and supplies synaptic weights and neuron thresholds to the spiking network. The block oversamples the SPI signals on the system clock, decodes 16-bit write/read frames, updates a bank of 8-bit registers, and returns read data on cipo.

---
 rtl/snn_spi_pkg.sv | 26 ++
 rtl/spi_sync_edge.sv | 43 ++++
 rtl/snn_spi_regfile.sv | 213 +++++++++++++++++++++
 tb/tb_snn_spi_regfile.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_spi_pkg.sv
// snn_spi_pkg
// Shared constants and the frame-decoder state type for the SNN SPI
// configuration block.
//   FRAME_W  : bits per SPI frame
//   ADDR_W   : register address width
//   RW_BIT   : frame bit selecting write (1) or read (0)
//   ADDR_MSB / ADDR_LSB : address field position within the frame
//   HDR_W    : header length (rw + addr + reserved); read data loads after it
//   CNT_W    : width of the per-frame rising-edge counter
package snn_spi_pkg;

    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 4;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 11;
    localparam int HDR_W    = 8;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Two-flop synchronizer for one asynchronous input, followed by a history
// flop that yields single-cycle rise/fall pulses on the synchronized level.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   din    : asynchronous input
//   sync   : synchronized level (2 clk latency)
//   rise   : one-clk pulse on a synchronized 0->1 transition
//   fall   : one-clk pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the line's idle level so no false edge appears on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/snn_spi_regfile.sv
// snn_spi_regfile
// SPI mode-0 target feeding a bank of 8-bit configuration registers
// (synaptic weights / neuron thresholds). SPI pins are oversampled on clk.
// Frame: 16 bits MSB first = {rw, addr[3:0], rsvd[2:0], data[7:0]}.
// Ports:
//   clk        : system clock, at least 4x sclk
//   rst_n      : asynchronous active-low reset
//   sclk       : SPI clock (idles low)
//   cs_n       : SPI chip select, active low
//   copi       : SPI data in
//   cipo       : SPI data out, read data MSB first
//   regs_flat  : all registers, reg 0 in the LSBs
//   wr_strobe  : one-clk pulse on each committed register write
//   wr_addr    : address of the last committed write
//
// state | meaning
// IDLE  | cs_n high; bit counter, shifter and read path held clear
// SHIFT | frame in progress; counting sclk rising edges 0..15
// DONE  | 16 bits taken; further edges ignored until cs_n rises
module snn_spi_regfile
    import snn_spi_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       copi,
    output logic                       cipo,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int HDR_OFF = FRAME_W - HDR_W;

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise, cs_fall;
    logic copi_meta_q, copi_s;
    logic unused_sync_sigs;

    spi_state_e state_q, state_d;

    logic [CNT_W-1:0]   bit_cnt_q;
    logic [FRAME_W-1:0] shift_q;
    logic [FRAME_W-1:0] frame_next;
    logic [DATA_W-1:0]  out_shift_q;
    logic               rd_active_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic [DATA_W-1:0]  rd_value;

    logic               clr_frame, shift_en, shift_out, commit_wr, load_rd;
    logic               hdr_rw;
    logic [ADDR_W-1:0]  hdr_addr, cmt_addr;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (sclk),
        .sync (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (cs_n),
        .sync (cs_n_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // copi only needs the level; it shares the sclk path latency so the
    // sampled bit lines up with the rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_meta_q <= 1'b0;
            copi_s      <= 1'b0;
        end else begin
            copi_meta_q <= copi;
            copi_s      <= copi_meta_q;
        end
    end

    // The decoder works on chip-select level, so these are intentionally idle.
    assign unused_sync_sigs = &{1'b0, sclk_s, cs_rise, cs_fall};

    // Frame contents as they will be after the current rising edge; used to
    // decode the header at bit 8 and commit the write at bit 16 without an
    // extra cycle of latency.
    assign frame_next = {shift_q[FRAME_W-2:0], copi_s};
    assign hdr_rw     = frame_next[RW_BIT-HDR_OFF];
    assign hdr_addr   = frame_next[ADDR_MSB-HDR_OFF:ADDR_LSB-HDR_OFF];
    assign cmt_addr   = frame_next[ADDR_MSB:ADDR_LSB];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!cs_n_s) state_d = SHIFT;
            end
            SHIFT: begin
                if (cs_n_s) begin
                    state_d = IDLE;
                end else if (sclk_rise && bit_cnt_q == CNT_W'(FRAME_W-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cs_n_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        clr_frame = 1'b0;
        shift_en  = 1'b0;
        shift_out = 1'b0;
        case (state_q)
            IDLE: clr_frame = 1'b1;
            SHIFT: begin
                if (!cs_n_s) begin
                    shift_en  = sclk_rise;
                    shift_out = sclk_fall & rd_active_q;
                end
            end
            default: ;
        endcase
        commit_wr = shift_en && (bit_cnt_q == CNT_W'(FRAME_W-1)) &&
                    frame_next[RW_BIT] && (int'(cmt_addr) < NUM_REGS);
        load_rd   = shift_en && (bit_cnt_q == CNT_W'(HDR_W-1)) && !hdr_rw;
    end

    // Out-of-range addresses match no register and fall through to zero.
    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_addr == ADDR_W'(i)) rd_value = regs_q[i];
        end
    end

    // Frame shifter, bit counter and read-data output path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_shift_q <= '0;
            rd_active_q <= 1'b0;
            cipo        <= 1'b0;
        end else if (clr_frame) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_shift_q <= '0;
            rd_active_q <= 1'b0;
            cipo        <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_q   <= frame_next;
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (load_rd) begin
                out_shift_q <= rd_value;
                rd_active_q <= 1'b1;
            end else if (shift_out) begin
                cipo        <= out_shift_q[DATA_W-1];
                out_shift_q <= {out_shift_q[DATA_W-2:0], 1'b0};
            end
            // Leaving SHIFT (abort or DONE) parks cipo low.
            if (state_d != SHIFT) begin
                cipo        <= 1'b0;
                rd_active_q <= 1'b0;
            end
        end
    end

    // Register bank and write reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= commit_wr;
            if (commit_wr) begin
                wr_addr <= cmt_addr;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cmt_addr == ADDR_W'(i)) regs_q[i] <= frame_next[DATA_W-1:0];
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end

endmodule

// File: tb/tb_snn_spi_regfile.sv
module tb_snn_spi_regfile;
    import snn_spi_pkg::*;

    localparam int NR = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sclk = 1'b0;
    logic            cs_n = 1'b1;
    logic            copi = 1'b0;
    logic            cipo;
    logic [NR*8-1:0] regs_flat;
    logic            wr_strobe;
    logic [3:0]      wr_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  model [NR];
    logic [11:0] exp_wr_q[$];
    logic [11:0] obs_wr_q[$];
    logic        exp_cipo_q[$];
    logic        obs_cipo_q[$];

    snn_spi_regfile #(.NUM_REGS(NR), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .copi     (copi),
        .cipo     (cipo),
        .regs_flat(regs_flat),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr)
    );

    always #5 clk = ~clk;

    // One entry per high cycle of wr_strobe, so a wide pulse shows up as extras.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) obs_wr_q.push_back({wr_addr, regs_flat[wr_addr*8 +: 8]});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mk_frame(input logic rw, input logic [3:0] a,
                                             input logic [2:0] rsv, input logic [7:0] d);
        return {rw, a, rsv, d};
    endfunction

    function automatic logic [NR*8-1:0] model_flat();
        logic [NR*8-1:0] v;
        for (int i = 0; i < NR; i++) v[i*8 +: 8] = model[i];
        return v;
    endfunction

    // Drives one SPI mode-0 frame at sclk = clk/8 and fills the scoreboard:
    // expected cipo/writes are pushed as bits are driven, observed cipo is
    // sampled just before each rising sclk edge.
    task automatic spi_frame(input logic [15:0] frame, input int nbits, input bit keep_cs);
        logic       is_rd;
        logic [3:0] a;
        logic [7:0] rd_exp;
        is_rd  = !frame[15];
        a      = frame[14:11];
        rd_exp = 8'h00;
        if (is_rd && a < NR) rd_exp = model[a[2:0]];
        if (!is_rd && nbits >= 16 && a < NR) begin
            model[a[2:0]] = frame[7:0];
            exp_wr_q.push_back({a, frame[7:0]});
        end
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            if (b < 16) copi = frame[15-b];
            else        copi = 1'b1;
            if (is_rd && b >= 8 && b < 16) exp_cipo_q.push_back(rd_exp[15-b]);
            else                           exp_cipo_q.push_back(1'b0);
            repeat (4) @(negedge clk);
            obs_cipo_q.push_back(cipo);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        if (!keep_cs) begin
            if (nbits >= 16) begin
                exp_cipo_q.push_back(1'b0);
                repeat (4) @(negedge clk);
                obs_cipo_q.push_back(cipo);
            end
            cs_n = 1'b1;
            copi = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (regs_flat !== '0) begin n_fail++; $display("FAIL rst_hold_regs got=%h exp=0", regs_flat); end
        n_checks++; if (cipo !== 1'b0) begin n_fail++; $display("FAIL rst_hold_cipo got=%b exp=0", cipo); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (regs_flat !== '0) begin n_fail++; $display("FAIL rst_regs got=%h exp=0", regs_flat); end
        n_checks++; if (cipo !== 1'b0) begin n_fail++; $display("FAIL rst_cipo got=%b exp=0", cipo); end
        n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL rst_strobe got=%b exp=0", wr_strobe); end
        n_checks++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
    endtask

    task automatic test_write_basic();
        logic [11:0] e, o;
        spi_frame(mk_frame(1'b1, 4'd3, 3'd0, 8'hA5), 16, 1'b0);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_fail++; $display("FAIL wb_strobe_cycles got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL wb_addr_data got=%h exp=%h", o, e); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        n_checks++; if (regs_flat !== model_flat()) begin n_fail++; $display("FAIL wb_regs got=%h exp=%h", regs_flat, model_flat()); end
        n_checks++; if (wr_addr !== 4'd3) begin n_fail++; $display("FAIL wb_wr_addr got=%0d exp=3", wr_addr); end
        while (exp_cipo_q.size() > 0 && obs_cipo_q.size() > 0) begin
            n_checks++;
            if (obs_cipo_q[0] !== exp_cipo_q[0]) begin n_fail++; $display("FAIL wb_cipo got=%b exp=%b", obs_cipo_q[0], exp_cipo_q[0]); end
            void'(obs_cipo_q.pop_front()); void'(exp_cipo_q.pop_front());
        end
    endtask

    task automatic test_write_read();
        logic [11:0] e, o;
        int bit_i;
        spi_frame(mk_frame(1'b1, 4'd3, 3'd0, 8'h3C), 16, 1'b0);
        spi_frame(mk_frame(1'b0, 4'd3, 3'd0, 8'hFF), 16, 1'b0);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_fail++; $display("FAIL wr_strobe_cycles got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL wr_addr_data got=%h exp=%h", o, e); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        bit_i = 0;
        while (exp_cipo_q.size() > 0 && obs_cipo_q.size() > 0) begin
            n_checks++;
            if (obs_cipo_q[0] !== exp_cipo_q[0]) begin
                n_fail++; $display("FAIL rd_cipo sample=%0d got=%b exp=%b", bit_i, obs_cipo_q[0], exp_cipo_q[0]);
            end
            void'(obs_cipo_q.pop_front()); void'(exp_cipo_q.pop_front());
            bit_i++;
        end
    endtask

    task automatic test_abort();
        logic [11:0] e, o;
        spi_frame(mk_frame(1'b1, 4'd5, 3'd0, 8'hE7), 10, 1'b0);
        n_checks++; if (obs_wr_q.size() != 0) begin n_fail++; $display("FAIL abort_strobe got=%0d exp=0", obs_wr_q.size()); end
        n_checks++; if (regs_flat !== model_flat()) begin n_fail++; $display("FAIL abort_regs got=%h exp=%h", regs_flat, model_flat()); end
        obs_wr_q.delete();
        spi_frame(mk_frame(1'b1, 4'd5, 3'd0, 8'h5A), 16, 1'b0);
        spi_frame(mk_frame(1'b0, 4'd5, 3'd0, 8'h00), 16, 1'b0);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_fail++; $display("FAIL after_abort_strobe got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL after_abort_wr got=%h exp=%h", o, e); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        n_checks++; if (regs_flat !== model_flat()) begin n_fail++; $display("FAIL after_abort_regs got=%h exp=%h", regs_flat, model_flat()); end
        while (exp_cipo_q.size() > 0 && obs_cipo_q.size() > 0) begin
            n_checks++;
            if (obs_cipo_q[0] !== exp_cipo_q[0]) begin n_fail++; $display("FAIL abort_cipo got=%b exp=%b", obs_cipo_q[0], exp_cipo_q[0]); end
            void'(obs_cipo_q.pop_front()); void'(exp_cipo_q.pop_front());
        end
    endtask

    task automatic test_overlength_range();
        logic [11:0] e, o;
        spi_frame(mk_frame(1'b1, 4'd2, 3'd0, 8'hC3), 20, 1'b0);
        spi_frame(mk_frame(1'b1, 4'd12, 3'd0, 8'h77), 16, 1'b0);
        spi_frame(mk_frame(1'b0, 4'd12, 3'd0, 8'h00), 16, 1'b0);
        spi_frame(mk_frame(1'b0, 4'd2, 3'd0, 8'h00), 16, 1'b0);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_fail++; $display("FAIL ovl_strobe_cycles got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL ovl_wr got=%h exp=%h", o, e); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        n_checks++; if (regs_flat !== model_flat()) begin n_fail++; $display("FAIL ovl_regs got=%h exp=%h", regs_flat, model_flat()); end
        while (exp_cipo_q.size() > 0 && obs_cipo_q.size() > 0) begin
            n_checks++;
            if (obs_cipo_q[0] !== exp_cipo_q[0]) begin n_fail++; $display("FAIL ovl_cipo got=%b exp=%b", obs_cipo_q[0], exp_cipo_q[0]); end
            void'(obs_cipo_q.pop_front()); void'(exp_cipo_q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e, o;
        for (int i = 0; i < NR; i++)
            spi_frame(mk_frame(1'b1, 4'(i), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))), 16, 1'b0);
        for (int i = 0; i < NR; i++)
            spi_frame(mk_frame(1'b0, 4'(i), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255))), 16, 1'b0);
        spi_frame(mk_frame(1'b0, 4'd15, 3'd0, 8'h00), 16, 1'b0);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_fail++; $display("FAIL b2b_strobe_cycles got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_wr got=%h exp=%h", o, e); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        n_checks++; if (regs_flat !== model_flat()) begin n_fail++; $display("FAIL b2b_regs got=%h exp=%h", regs_flat, model_flat()); end
        while (exp_cipo_q.size() > 0 && obs_cipo_q.size() > 0) begin
            n_checks++;
            if (obs_cipo_q[0] !== exp_cipo_q[0]) begin n_fail++; $display("FAIL b2b_cipo got=%b exp=%b", obs_cipo_q[0], exp_cipo_q[0]); end
            void'(obs_cipo_q.pop_front()); void'(exp_cipo_q.pop_front());
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] e, o;
        spi_frame(mk_frame(1'b0, 4'd3, 3'd0, 8'h00), 6, 1'b1);
        copi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (cipo !== 1'b0) begin n_fail++; $display("FAIL mid_rst_cipo got=%b exp=0", cipo); end
        n_checks++; if (regs_flat !== '0) begin n_fail++; $display("FAIL mid_rst_regs got=%h exp=0", regs_flat); end
        n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL mid_rst_strobe got=%b exp=0", wr_strobe); end
        n_checks++; if (wr_addr !== 4'd0) begin n_fail++; $display("FAIL mid_rst_wr_addr got=%0d exp=0", wr_addr); end
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL mid_rst_state got=%0d exp=%0d", dut.state_q, IDLE); end
        spi_frame(mk_frame(1'b1, 4'd4, 3'd0, 8'h96), 16, 1'b0);
        spi_frame(mk_frame(1'b0, 4'd4, 3'd0, 8'h00), 16, 1'b0);
        n_checks++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_fail++; $display("FAIL post_rst_strobe got=%0d exp=%0d", obs_wr_q.size(), exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front(); o = obs_wr_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL post_rst_wr got=%h exp=%h", o, e); end
        end
        exp_wr_q.delete(); obs_wr_q.delete();
        n_checks++; if (regs_flat !== model_flat()) begin n_fail++; $display("FAIL post_rst_regs got=%h exp=%h", regs_flat, model_flat()); end
        while (exp_cipo_q.size() > 0 && obs_cipo_q.size() > 0) begin
            n_checks++;
            if (obs_cipo_q[0] !== exp_cipo_q[0]) begin n_fail++; $display("FAIL post_rst_cipo got=%b exp=%b", obs_cipo_q[0], exp_cipo_q[0]); end
            void'(obs_cipo_q.pop_front()); void'(exp_cipo_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_read();
        test_abort();
        test_overlength_range();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
